// File: rtl/nmix_tag_accum_if.sv
// Bus bundle between the nmix mixing stage / result consumer and the tag accumulator.
interface nmix_tag_accum_if #(
  parameter int WIDTH = 32
);
  logic             y_valid;
  logic             y_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_last;
  logic [WIDTH-1:0] ref_tag;
  logic             ref_valid;
  logic [WIDTH-1:0] tag;
  logic             tag_valid;
  logic             tag_match;
  logic             err_len;
  logic             out_ack;

  modport master (
    output y_valid, y_data, y_last, ref_tag, ref_valid, out_ack,
    input  y_ready, tag, tag_valid, tag_match, err_len
  );

  modport slave (
    input  y_valid, y_data, y_last, ref_tag, ref_valid, out_ack,
    output y_ready, tag, tag_valid, tag_match, err_len
  );
endinterface

// File: rtl/nmix_tag_accum.sv
// MAC tag accumulator: folds mixed words into a rotate/XOR accumulator, then
// emits a tag plus a compare against a received reference tag and holds it
// until the consumer acknowledges.
module nmix_tag_accum #(
  parameter int          WIDTH     = 32,
  parameter int          MAX_WORDS = 16,
  parameter int          ROT       = 5,
  parameter logic [31:0] IV        = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  nmix_tag_accum_if.slave  bus
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int RS = ROT % WIDTH;
  localparam logic [WIDTH-1:0] IV_W = IV[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, HOLD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] tag_reg, tag_next;
  logic             match_reg, match_next;
  logic             err_reg, err_next;
  logic             ref_seen, ref_seen_next;
  logic [WIDTH-1:0] ref_reg, ref_next;

  logic             transfer;
  logic [CW-1:0]    count_inc;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] computed_tag;
  logic [WIDTH-1:0] cmp_ref;
  logic             cmp_seen;

  // Full-width circular left rotate.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
    if (RS == 0) return v;
    return (v << RS) | (v >> (WIDTH - RS));
  endfunction

  assign bus.y_ready   = (state == IDLE) || (state == ACCUM);
  assign bus.tag_valid = (state == HOLD);
  assign bus.tag       = tag_reg;
  assign bus.tag_match = match_reg;
  assign bus.err_len   = err_reg;

  assign transfer     = bus.y_valid && bus.y_ready;
  assign count_inc    = count + CW'(1);
  assign acc_step     = rotl(acc) ^ bus.y_data;
  assign computed_tag = acc + WIDTH'(count);
  // A reference arriving in the same cycle as FINAL must take part in the compare.
  assign cmp_ref      = bus.ref_valid ? bus.ref_tag : ref_reg;
  assign cmp_seen     = bus.ref_valid || ref_seen;

  // Next-state and datapath decode; every register holds unless a rule below fires.
  always_comb begin
    state_next    = state;
    acc_next      = acc;
    count_next    = count;
    tag_next      = tag_reg;
    match_next    = match_reg;
    err_next      = err_reg;
    ref_seen_next = ref_seen;
    ref_next      = ref_reg;

    if (state != HOLD && bus.ref_valid) begin
      ref_next      = bus.ref_tag;
      ref_seen_next = 1'b1;
    end

    case (state)
      IDLE: begin
        if (transfer) begin
          acc_next   = acc_step;
          count_next = CW'(1);
          state_next = bus.y_last ? FINAL : ACCUM;
        end
      end
      ACCUM: begin
        if (transfer) begin
          acc_next   = acc_step;
          count_next = count_inc;
          if (bus.y_last) begin
            state_next = FINAL;
          end else if (count_inc == CW'(MAX_WORDS)) begin
            err_next   = 1'b1;
            state_next = FINAL;
          end
        end
      end
      FINAL: begin
        tag_next   = computed_tag;
        match_next = cmp_seen && (cmp_ref == computed_tag) && !err_reg;
        state_next = HOLD;
      end
      HOLD: begin
        if (bus.out_ack) begin
          match_next    = 1'b0;
          err_next      = 1'b0;
          ref_seen_next = 1'b0;
          acc_next      = IV_W;
          count_next    = '0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= IV_W;
      count     <= '0;
      tag_reg   <= '0;
      match_reg <= 1'b0;
      err_reg   <= 1'b0;
      ref_seen  <= 1'b0;
      ref_reg   <= '0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      count     <= count_next;
      tag_reg   <= tag_next;
      match_reg <= match_next;
      err_reg   <= err_next;
      ref_seen  <= ref_seen_next;
      ref_reg   <= ref_next;
    end
  end

endmodule

// File: doc/nmix_tag_accum.md
Name: nmix_tag_accum

Overview:
- Downstream consumer of the nmix mixing stage.
- Accepts the stream of 32-bit mixed words Y produced per message word and folds them into a running MAC accumulator.
- At end of frame it emits a 32-bit tag and a compare result against a received reference tag, for the integrated ECC/MAC check path.
- Holds the result until acknowledged, then re-arms for the next frame.

Parameters:
- WIDTH, 32, data/tag width in bits.
- MAX_WORDS, 16, maximum words per frame; also sets the counter width, clog2(MAX_WORDS+1).
- ROT, 5, left-rotate amount applied to the accumulator per word.
- IV, 32'h0000_0001, accumulator initial value at frame start.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- y_valid  input  1  nmix output word valid.
- y_ready  output  1  block can accept a word this cycle.
- y_data  input  WIDTH  mixed word Y from nmix.
- y_last  input  1  current word is the last of the frame.
- ref_tag  input  WIDTH  received tag to compare against.
- ref_valid  input  1  ref_tag is valid this cycle.
- tag  output  WIDTH  final computed tag.
- tag_valid  output  1  tag, tag_match and err_len are valid.
- tag_match  output  1  computed tag equals the captured ref_tag.
- err_len  output  1  frame exceeded MAX_WORDS without y_last.
- out_ack  input  1  consumer accepts the result.

Behaviour:
- Reset (reset=0, async) clears everything immediately: state=IDLE, acc=IV, count=0, tag=0, tag_valid=0, tag_match=0, err_len=0, ref_seen=0, ref_reg=0.
- Reset mid-frame discards the partial frame.
- Word transfer occurs on a rising clk edge where y_valid && y_ready.
- y_ready is decoded from state: 1 in IDLE and ACCUM, 0 in FINAL and HOLD.
- Accumulator update per accepted word: acc <= rotl(acc, ROT) XOR y_data. rotl is a full-width circular rotate.
- count increments by 1 per accepted word.
- State IDLE:
  - acc holds IV and count=0.
  - On transfer: apply the update to IV and set count=1.
  - If y_last, go to FINAL; else go to ACCUM.
- State ACCUM:
  - On transfer, apply the update.
  - If y_last, go to FINAL.
  - Else, if the word just accepted is the MAX_WORDS-th, set err_len<=1 and go to FINAL.
  - Otherwise stay in ACCUM.
  - With no transfer, all state holds.
- State FINAL (exactly one cycle):
  - tag <= (acc + count) mod 2^WIDTH, with count zero-extended.
  - tag_match <= ref_seen && (ref_reg == computed tag) && !err_len.
  - Go to HOLD.
- State HOLD:
  - tag_valid=1; tag, tag_match and err_len are stable.
  - On out_ack: next cycle tag_valid=0, tag_match=0, err_len=0, ref_seen=0, acc=IV, count=0, go to IDLE.
  - out_ack is ignored in all other states.
- Reference capture:
  - In IDLE, ACCUM and FINAL, ref_valid=1 loads ref_reg<=ref_tag and sets ref_seen=1.
  - Later ref_valid overwrites earlier values.
  - ref_valid is ignored in HOLD.
  - A ref_valid in FINAL is visible to that cycle's compare.
- No ref_tag seen during the frame gives tag_match=0.
- Latency: last word accepted at edge N; FINAL occupies cycle N..N+1; tag_valid rises after edge N+1. Minimum frame-to-frame spacing is 3 cycles plus the ack wait.
- A word exactly MAX_WORDS long with y_last on the final word is legal: err_len=0.
- y_last=1 together with the MAX_WORDS-th word takes the y_last path: no error.
- All arithmetic is unsigned and wraps modulo 2^WIDTH; no saturation.

Test Plan:
- Reset release, then 1-word frame y_data=0x00000010, y_last=1, no ref -> tag=0x00000031, tag_match=0, err_len=0, tag_valid 2 edges after transfer.
- 2-word frame 0x00000001, 0x00000002 (last), ref_tag=0x00000424 presented during frame -> tag=0x00000424, tag_match=1. Same frame with ref_tag=0x00000425 -> tag_match=0.
- Stalls: gaps of 3 cycles with y_valid=0 between the words of the 2-word frame -> identical tag 0x00000424. y_valid held high during FINAL/HOLD -> y_ready=0, no words consumed.
- Overlength: MAX_WORDS=16 words of 0x0 with y_last=0 -> after the 16th word err_len=1, tag=rotl^16(IV)+16, i.e. 0x00000001 rotated left by 80 (=16) plus 16 = 0x00010010, tag_match=0 even with matching ref. Exactly 16 words with last on the 16th -> err_len=0.
- Hold/ack: keep out_ack=0 for 10 cycles -> outputs stable. Pulse out_ack -> tag_valid=0 next cycle, y_ready=1, next frame starts from IV.
- Async reset asserted mid-ACCUM between clock edges -> outputs clear immediately without a clk edge. After release, 1-word frame 0x10 -> tag=0x31.
